y86_writeback_regfile: RTL and testbench

Consumer end of the Y86 writeback pipeline register: samples the W-stage fields every cycle and commits them architecturally. Holds the 15-entry register file (dstE/dstM write ports, srcA/srcB combinational read ports for decode) and the sticky processor-status state machine. Counts retired instructions. Sits after the writeback pipeline register and feeds decode and the top-level halt logic.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/y86_writeback_regfile_if.sv | 32 +++
 rtl/y86_wb_status_fsm.sv | 49 ++++
 rtl/y86_writeback_regfile.sv | 81 ++++++++
 tb/tb_y86_writeback_regfile.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 constants: status codes, register IDs, icodes and the
// writeback status-machine state type.
package y86_pkg;

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam int         NUM_REGS = 15;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Encodings equal the architectural status code each state reports.
  typedef enum logic [2:0] {
    RUN     = 3'd1,
    HALTED  = 3'd2,
    ERR_ADR = 3'd3,
    ERR_INS = 3'd4
  } wb_state_e;

endpackage

// File: rtl/y86_writeback_regfile_if.sv
// W-stage fields, decode read ports and status outputs of the writeback
// register file, bundled with pipeline-side (master) and regfile (slave) views.
interface y86_writeback_regfile_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
);
  logic        [2:0]      W_stat;
  logic        [3:0]      W_Ins_Code;
  logic signed [XLEN-1:0] W_Value_E;
  logic signed [XLEN-1:0] W_Value_M;
  logic        [3:0]      W_dstE;
  logic        [3:0]      W_dstM;
  logic        [3:0]      d_srcA;
  logic        [3:0]      d_srcB;
  logic signed [XLEN-1:0] d_rvalA;
  logic signed [XLEN-1:0] d_rvalB;
  logic        [2:0]      cpu_stat;
  logic                   cpu_halt;
  logic        [CNT_W-1:0] retired_count;

  modport master (
    output W_stat, W_Ins_Code, W_Value_E, W_Value_M, W_dstE, W_dstM,
           d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, cpu_stat, cpu_halt, retired_count
  );

  modport slave (
    input  W_stat, W_Ins_Code, W_Value_E, W_Value_M, W_dstE, W_dstM,
           d_srcA, d_srcB,
    output d_rvalA, d_rvalB, cpu_stat, cpu_halt, retired_count
  );
endinterface

// File: rtl/y86_wb_status_fsm.sv
// Sticky processor-status machine: decides per W entry whether it commits,
// retires, or moves the core into a halted/error state that holds until reset.
module y86_wb_status_fsm
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] w_stat,
  output logic [2:0] cpu_stat,
  output logic       cpu_halt,
  output logic       commit_en,
  output logic       count_en
);

  wb_state_e state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    commit_en  = 1'b0;
    count_en   = 1'b0;
    if (state == RUN) begin
      case (w_stat)
        STAT_BUB: ;
        STAT_AOK: begin
          commit_en = 1'b1;
          count_en  = 1'b1;
        end
        STAT_HLT: begin
          count_en   = 1'b1;
          state_next = HALTED;
        end
        STAT_ADR: state_next = ERR_ADR;
        default:  state_next = ERR_INS;
      endcase
    end
  end

  assign cpu_stat = state;
  assign cpu_halt = (state != RUN);

endmodule

// File: rtl/y86_writeback_regfile.sv
// Y86 writeback commit stage: 15-entry register file, decode read ports and
// retired-instruction counter. `WB_REGFILE_BYPASS_EN forwards same-cycle commits to reads.
module y86_writeback_regfile
  import y86_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  y86_writeback_regfile_if.slave wb
);

  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [CNT_W-1:0] retired_count;
  logic             commit_en;
  logic             count_en;
  logic [XLEN-1:0]  stored_a;
  logic [XLEN-1:0]  stored_b;
  logic             unused_ins_code;

  assign unused_ins_code = ^wb.W_Ins_Code;

  y86_wb_status_fsm u_status (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_stat    (wb.W_stat),
    .cpu_stat  (wb.cpu_stat),
    .cpu_halt  (wb.cpu_halt),
    .commit_en (commit_en),
    .count_en  (count_en)
  );

  // NOTE: the array is cleared on reset because architectural state must read
  // zero straight out of reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit_en) begin
      // M is written last so it overrides E on a shared destination (popq %rsp).
      if (wb.W_dstE != RNONE) regs[wb.W_dstE] <= wb.W_Value_E;
      if (wb.W_dstM != RNONE) regs[wb.W_dstM] <= wb.W_Value_M;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        retired_count <= '0;
    else if (count_en) retired_count <= retired_count + CNT_W'(1);
  end

  assign wb.retired_count = retired_count;

  assign stored_a = (wb.d_srcA == RNONE) ? '0 : regs[wb.d_srcA];
  assign stored_b = (wb.d_srcB == RNONE) ? '0 : regs[wb.d_srcB];

`ifdef WB_REGFILE_BYPASS_EN
  function automatic logic [XLEN-1:0] forward(
    input logic [3:0]      src,
    input logic [XLEN-1:0] stored,
    input logic            commit,
    input logic [3:0]      dst_e,
    input logic [XLEN-1:0] val_e,
    input logic [3:0]      dst_m,
    input logic [XLEN-1:0] val_m
  );
    if (!commit || src == RNONE) return stored;
    if (src == dst_m)            return val_m;
    if (src == dst_e)            return val_e;
    return stored;
  endfunction

  assign wb.d_rvalA = forward(wb.d_srcA, stored_a, commit_en, wb.W_dstE,
                              wb.W_Value_E, wb.W_dstM, wb.W_Value_M);
  assign wb.d_rvalB = forward(wb.d_srcB, stored_b, commit_en, wb.W_dstE,
                              wb.W_Value_E, wb.W_dstM, wb.W_Value_M);
`else
  assign wb.d_rvalA = stored_a;
  assign wb.d_rvalB = stored_b;
`endif

endmodule

// File: tb/tb_y86_writeback_regfile.sv
// Randomized scoreboard bench for y86_writeback_regfile: stimulus pushes expected
// outputs from an architectural model; a negedge monitor pops and compares.
module tb_y86_writeback_regfile;
  import y86_pkg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 64;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] count;
    logic [2:0]  stat;
    logic        halt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  // Architectural model: register values, status code, retired count.
  logic [63:0] m_regs [15];
  logic [2:0]  m_stat;
  logic [63:0] m_count;

  y86_writeback_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) wb ();

  y86_writeback_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_stat  = STAT_AOK;
    m_count = '0;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] src, input logic [2:0] st,
                                         input logic [3:0] de, input logic [63:0] ve,
                                         input logic [3:0] dm, input logic [63:0] vm);
    if (src == 4'hF) return '0;
`ifdef WB_REGFILE_BYPASS_EN
    if (m_stat == STAT_AOK && st == STAT_AOK) begin
      if (src == dm) return vm;
      if (src == de) return ve;
    end
`endif
    return m_regs[src];
  endfunction

  function automatic void m_step(input logic [2:0] st, input logic [3:0] de,
                                 input logic [63:0] ve, input logic [3:0] dm,
                                 input logic [63:0] vm);
    if (m_stat != STAT_AOK) return;
    case (st)
      STAT_BUB: ;
      STAT_AOK: begin
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
        m_count++;
      end
      STAT_HLT: begin
        m_count++;
        m_stat = STAT_HLT;
      end
      STAT_ADR: m_stat = STAT_ADR;
      default:  m_stat = STAT_INS;
    endcase
  endfunction

  function automatic void drive_and_expect(input logic [2:0] st, input logic [3:0] de,
                                           input logic [63:0] ve, input logic [3:0] dm,
                                           input logic [63:0] vm, input logic [3:0] sa,
                                           input logic [3:0] sb);
    exp_t e;
    wb.W_stat     = st;
    wb.W_Ins_Code = ICODE_NOP;
    wb.W_dstE     = de;
    wb.W_Value_E  = ve;
    wb.W_dstM     = dm;
    wb.W_Value_M  = vm;
    wb.d_srcA     = sa;
    wb.d_srcB     = sb;
    e.a     = m_read(sa, st, de, ve, dm, vm);
    e.b     = m_read(sb, st, de, ve, dm, vm);
    e.count = m_count;
    e.stat  = m_stat;
    e.halt  = (m_stat != STAT_AOK);
    q.push_back(e);
  endfunction

  // One W entry; while reset is held the bench only issues bubbles.
  task automatic cycle(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb);
    logic [2:0] s;
    @(posedge clk);
    #1;
    s = rst_n ? st : STAT_BUB;
    drive_and_expect(s, de, ve, dm, vm, sa, sb);
    if (rst_n) m_step(s, de, ve, dm, vm);
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_reset();
    drive_and_expect(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // An AOK write is in flight when reset drops before the edge: it must be lost.
  task automatic reset_mid_commit(input logic [3:0] r);
    @(posedge clk);
    #1;
    drive_and_expect(STAT_AOK, r, {$urandom, $urandom}, 4'hF, '0, r, 4'hF);
    #6;
    rst_n     = 1'b0;
    wb.W_stat = STAT_BUB;
    m_reset();
  endtask

  function automatic logic [2:0] rand_stat();
    int r = $urandom_range(0, 99);
    if (r < 55) return STAT_AOK;
    if (r < 85) return STAT_BUB;
    if (r < 90) return STAT_HLT;
    if (r < 94) return STAT_ADR;
    if (r < 97) return STAT_INS;
    return 3'($urandom_range(5, 7));
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("d_rvalA", wb.d_rvalA, e.a);
      check("d_rvalB", wb.d_rvalB, e.b);
      check("cpu_stat", {61'd0, wb.cpu_stat}, {61'd0, e.stat});
      check("cpu_halt", {63'd0, wb.cpu_halt}, {63'd0, e.halt});
      check("retired_count", wb.retired_count, e.count);
    end
  end

  initial begin
    rst_n         = 1'b0;
    wb.W_stat     = STAT_BUB;
    wb.W_Ins_Code = ICODE_NOP;
    wb.W_Value_E  = '0;
    wb.W_Value_M  = '0;
    wb.W_dstE     = 4'hF;
    wb.W_dstM     = 4'hF;
    wb.d_srcA     = 4'hF;
    wb.d_srcB     = 4'hF;
    m_reset();

    // Reset state: every register reads zero, status AOK, count zero.
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd0, 4'd1);
    release_reset();
    for (int i = 0; i < 16; i++) cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'(i), 4'(15 - i));

    // E-port write, visible next cycle.
    cycle(STAT_AOK, 4'd0, 64'h1234, 4'hF, '0, 4'd0, 4'd1);
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd0, 4'd0);
    // Shared destination: M wins.
    cycle(STAT_AOK, 4'd4, 64'd8, 4'd4, 64'hDEAD, 4'd4, 4'd4);
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd4, 4'd0);
    // Same-cycle read of an M write (forwarded only with bypass).
    cycle(STAT_AOK, 4'hF, '0, 4'd3, -64'sd5, 4'd3, 4'd3);
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd3, 4'd3);
    // HLT: no write, counted, then absorbing.
    cycle(STAT_HLT, 4'd2, 64'd99, 4'hF, '0, 4'd2, 4'd2);
    cycle(STAT_AOK, 4'd2, 64'd7, 4'd5, 64'd9, 4'd2, 4'd5);
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd2, 4'd5);
    // ADR then INS: stays ADR, count frozen.
    assert_reset();
    release_reset();
    cycle(STAT_ADR, 4'd1, 64'd11, 4'hF, '0, 4'd1, 4'd0);
    cycle(STAT_INS, 4'd1, 64'd12, 4'hF, '0, 4'd1, 4'd0);
    cycle(STAT_AOK, 4'd1, 64'd13, 4'hF, '0, 4'd1, 4'd0);
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd1, 4'd0);
    // Reset dropped mid-commit discards the write.
    assert_reset();
    release_reset();
    cycle(STAT_AOK, 4'd6, 64'h55, 4'hF, '0, 4'd6, 4'hF);
    reset_mid_commit(4'd7);
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd7, 4'd6);
    release_reset();
    cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'd7, 4'd6);

    for (int n = 0; n < 2000; n++) begin
      int r = $urandom_range(0, 999);
      if (!rst_n) begin
        if (r < 500) release_reset();
        else cycle(STAT_BUB, 4'hF, '0, 4'hF, '0, 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)));
      end else if (r < 30) begin
        assert_reset();
      end else if (r < 40) begin
        reset_mid_commit(4'($urandom_range(0, 14)));
      end else begin
        cycle(rand_stat(), 4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), {$urandom, $urandom},
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
